// File: rtl/cheri_pkg.sv
// Shared types and constants for the TBRE sequencer.
package cheri_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_REQ    = 3'd1,
    LD_WAIT   = 3'd2,
    TRVK_WAIT = 3'd3,
    ST_REQ    = 3'd4,
    ST_WAIT   = 3'd5,
    NEXT      = 3'd6
  } tbre_state_e;

  localparam int unsigned TBRE_CAP_STRIDE = 8;
  localparam int unsigned TBRE_RAW_W      = 65;

  // An end address of 0 means "top of the address space", so that a range
  // such as 0xFFFF_FFF0..0x0 covers the last slots instead of being empty.
  function automatic logic [32:0] tbre_end_ext(input logic [31:0] end_addr);
    return (end_addr == 32'h0) ? 33'h1_0000_0000 : {1'b0, end_addr};
  endfunction

endpackage

// File: rtl/cheri_tbre_stats.sv
// Saturating scan statistics: slots loaded cleanly and store-backs completed.
module cheri_tbre_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        scan_inc_i,
  input  logic        rvk_inc_i,
  output logic [31:0] scan_cnt_o,
  output logic [31:0] rvk_cnt_o
);

  // Both counters clear on a new scan and stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      scan_cnt_o <= '0;
      rvk_cnt_o  <= '0;
    end else begin
      if (scan_inc_i && (scan_cnt_o != '1)) scan_cnt_o <= scan_cnt_o + 32'd1;
      if (rvk_inc_i && (rvk_cnt_o != '1))   rvk_cnt_o  <= rvk_cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/cheri_tbre_ctrl.sv
// Background revocation engine sequencer: loads each 64-bit cap slot of a
// configured range, waits for the revocation verdict and writes back revoked
// caps with the tag cleared. Optional statistics under CHERI_TBRE_STATS_EN.
//
// LSU handshake: tbre_lsu_req_o is a valid that stays high with we/addr/wdata
// frozen until lsu_tbre_req_done_i (ready) is seen in the same cycle; only one
// request is ever outstanding, and its single response arrives later on
// lsu_tbre_resp_valid_i.
module cheri_tbre_ctrl
  import cheri_pkg::*;
#(
  parameter int unsigned TrvkTimeout = 8,
  parameter int unsigned CapStride   = TBRE_CAP_STRIDE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic                  cfg_stop_i,
  input  logic [31:0]           cfg_start_addr_i,
  input  logic [31:0]           cfg_end_addr_i,
  output logic                  tbre_busy_o,
  output logic                  tbre_done_o,
  output logic [15:0]           tbre_err_cnt_o,
  output logic                  tbre_lsu_req_o,
  output logic                  tbre_lsu_we_o,
  output logic [31:0]           tbre_lsu_addr_o,
  output logic [TBRE_RAW_W-1:0] tbre_lsu_wdata_o,
  input  logic                  lsu_tbre_req_done_i,
  input  logic                  lsu_tbre_resp_valid_i,
  input  logic                  lsu_tbre_resp_err_i,
  input  logic [TBRE_RAW_W-1:0] lsu_tbre_rdata_i,
  input  logic                  tbre_trvk_en_i,
  input  logic                  tbre_trvk_clrtag_i,
`ifdef CHERI_TBRE_STATS_EN
  output logic [31:0]           tbre_scan_cnt_o,
  output logic [31:0]           tbre_rvk_cnt_o,
`endif
  output tbre_state_e           tbre_state_o
);

  localparam int unsigned TmoW = (TrvkTimeout > 1) ? $clog2(TrvkTimeout) : 1;

  tbre_state_e           state_q, state_d;
  logic [31:0]           cur_q, end_q;
  logic [TBRE_RAW_W-1:0] rdata_q;
  logic [TmoW-1:0]       tmo_q;
  logic [15:0]           err_q;
  logic                  stop_q;

  logic                  start_acc;
  logic [32:0]           start_al, nxt_addr;
  logic                  last_slot;
  logic                  err_inc, capture, req, we, done;

  assign start_acc = (state_q == IDLE) && cfg_start_i;
  assign start_al  = {1'b0, cfg_start_addr_i & ~32'h7};
  // 33-bit increment: a carry out of slot 0xFFFF_FFF8 always ends the scan.
  assign nxt_addr  = {1'b0, cur_q} + 33'(CapStride);
  assign last_slot = (nxt_addr >= tbre_end_ext(end_q)) || stop_q;

  // Next-state and per-state outputs.
  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    capture = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          state_d = (start_al >= tbre_end_ext(cfg_end_addr_i & ~32'h7)) ? NEXT : LD_REQ;
        end
      end
      LD_REQ: begin
        req = 1'b1;
        if (lsu_tbre_req_done_i) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        if (lsu_tbre_resp_valid_i) begin
          if (lsu_tbre_resp_err_i) begin
            err_inc = 1'b1;
            state_d = NEXT;
          end else begin
            capture = 1'b1;
            state_d = TRVK_WAIT;
          end
        end
      end
      TRVK_WAIT: begin
        if (tbre_trvk_en_i) begin
          // A cap whose tag is already clear needs no store-back.
          state_d = (tbre_trvk_clrtag_i && rdata_q[64]) ? ST_REQ : NEXT;
        end else if (tmo_q == TmoW'(TrvkTimeout - 1)) begin
          err_inc = 1'b1;
          state_d = NEXT;
        end
      end
      ST_REQ: begin
        req = 1'b1;
        we  = 1'b1;
        if (lsu_tbre_req_done_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lsu_tbre_resp_valid_i) begin
          err_inc = lsu_tbre_resp_err_i;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (last_slot) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = LD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Range registers: latched on an accepted start, cursor stepped in NEXT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q <= '0;
      end_q <= '0;
    end else if (start_acc) begin
      cur_q <= start_al[31:0];
      end_q <= cfg_end_addr_i & ~32'h7;
    end else if (state_q == NEXT) begin
      cur_q <= nxt_addr[31:0];
    end
  end

  // Loaded cap, kept for the store-back data and the tag check.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rdata_q <= '0;
    else if (capture) rdata_q <= lsu_tbre_rdata_i;
  end

  // Verdict timeout: counts cycles spent in TRVK_WAIT, zero elsewhere.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != TRVK_WAIT)) tmo_q <= '0;
    else                                 tmo_q <= tmo_q + 1'b1;
  end

  // Saturating error count for the current scan.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc)             err_q <= '0;
    else if (err_inc && (err_q != '1))  err_q <= err_q + 16'd1;
  end

  // Sticky stop request; a stop arriving together with start limits the scan to one slot.
  always_ff @(posedge clk_i) begin
    if (rst_i)                  stop_q <= 1'b0;
    else if (state_q == IDLE)   stop_q <= cfg_start_i && cfg_stop_i;
    else if (state_d == IDLE)   stop_q <= 1'b0;
    else if (cfg_stop_i)        stop_q <= 1'b1;
  end

  assign tbre_busy_o      = (state_q != IDLE);
  assign tbre_done_o      = done;
  assign tbre_err_cnt_o   = err_q;
  assign tbre_lsu_req_o   = req;
  assign tbre_lsu_we_o    = we;
  assign tbre_lsu_addr_o  = req ? cur_q : 32'h0;
  assign tbre_lsu_wdata_o = (state_q == ST_REQ) ? {1'b0, rdata_q[63:0]} : '0;
  assign tbre_state_o     = state_q;

`ifdef CHERI_TBRE_STATS_EN
  logic scan_inc, rvk_inc;
  assign scan_inc = (state_q == LD_WAIT) && lsu_tbre_resp_valid_i && !lsu_tbre_resp_err_i;
  assign rvk_inc  = (state_q == ST_WAIT) && lsu_tbre_resp_valid_i && !lsu_tbre_resp_err_i;

  cheri_tbre_stats u_stats (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (start_acc),
    .scan_inc_i (scan_inc),
    .rvk_inc_i  (rvk_inc),
    .scan_cnt_o (tbre_scan_cnt_o),
    .rvk_cnt_o  (tbre_rvk_cnt_o)
  );
`endif

endmodule

// File: tb/tb_cheri_tbre_ctrl.sv
// Self-checking bench for cheri_tbre_ctrl: an LSU/revocation responder driven
// by a per-slot behaviour table, and a range-walk model producing the
// expected LSU transaction queue and error count for each scan.
module tb_cheri_tbre_ctrl;
  import cheri_pkg::*;

  localparam int MAXS = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        cfg_start = 1'b0, cfg_stop_main = 1'b0, stop_from_resp = 1'b0;
  logic [31:0] cfg_start_addr = '0, cfg_end_addr = '0;
  logic        req_done = 1'b0, resp_valid = 1'b0, resp_err = 1'b0;
  logic [64:0] rdata = '0;
  logic        trvk_en = 1'b0, trvk_clr = 1'b0;

  logic        busy, done, lsu_req, lsu_we;
  logic [15:0] err_cnt;
  logic [31:0] lsu_addr;
  logic [64:0] lsu_wdata;
  tbre_state_e dbg_state;
`ifdef CHERI_TBRE_STATS_EN
  logic [31:0] scan_cnt, rvk_cnt;
`endif

  cheri_tbre_ctrl dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .cfg_start_i           (cfg_start),
    .cfg_stop_i            (cfg_stop_main | stop_from_resp),
    .cfg_start_addr_i      (cfg_start_addr),
    .cfg_end_addr_i        (cfg_end_addr),
    .tbre_busy_o           (busy),
    .tbre_done_o           (done),
    .tbre_err_cnt_o        (err_cnt),
    .tbre_lsu_req_o        (lsu_req),
    .tbre_lsu_we_o         (lsu_we),
    .tbre_lsu_addr_o       (lsu_addr),
    .tbre_lsu_wdata_o      (lsu_wdata),
    .lsu_tbre_req_done_i   (req_done),
    .lsu_tbre_resp_valid_i (resp_valid),
    .lsu_tbre_resp_err_i   (resp_err),
    .lsu_tbre_rdata_i      (rdata),
    .tbre_trvk_en_i        (trvk_en),
    .tbre_trvk_clrtag_i    (trvk_clr),
`ifdef CHERI_TBRE_STATS_EN
    .tbre_scan_cnt_o       (scan_cnt),
    .tbre_rvk_cnt_o        (rvk_cnt),
`endif
    .tbre_state_o          (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-slot behaviour of the LSU and the revocation stage.
  logic        sl_lderr [MAXS];
  logic [64:0] sl_rdata [MAXS];
  int          sl_vdly  [MAXS];   // verdict delay after entering verdict wait, -1 = withheld
  logic        sl_clr   [MAXS];
  logic        sl_sterr [MAXS];

  logic [31:0] scan_start = '0;
  bit          stop_on_store = 0;
  int          resp_extra = 0;

  // Scoreboard: {we, addr, wdata} per expected LSU request.
  logic [97:0] exp_q[$];
  int          exp_err;

  int          done_seen = 0, acc_count = 0, n_loads = 0, n_stores = 0;
  logic [31:0] last_ld_addr = '0, last_st_addr = '0;
  logic [64:0] last_st_wdata = '0;

  task automatic set_slots();
    for (int i = 0; i < MAXS; i++) begin
      sl_lderr[i] = 1'b0;
      sl_rdata[i] = {1'b1, 32'hC0DE_0000 | 32'(i), 32'h0000_F000 | 32'(i)};
      sl_vdly[i]  = i % 3;
      sl_clr[i]   = 1'b0;
      sl_sterr[i] = 1'b0;
    end
  endtask

  // Range-walk model: every slot from start up to (exclusive) end is loaded;
  // errors and timeouts skip the slot; revoked tagged caps are stored back.
  task automatic build_expected(input logic [31:0] s, input logic [31:0] e,
                                input int max_slots, input bit stop_store);
    logic [32:0] base, lim, a;
    int          k;
    logic [97:0] item;
    exp_q.delete();
    exp_err = 0;
    base = {1'b0, s & ~32'h7};
    lim  = ((e & ~32'h7) == 32'h0) ? 33'h1_0000_0000 : {1'b0, e & ~32'h7};
    k = 0;
    for (a = base; a < lim; a = a + 33'd8) begin
      item = {1'b0, a[31:0], 65'h0};
      exp_q.push_back(item);
      k++;
      if (sl_lderr[k-1]) exp_err++;
      else if (sl_vdly[k-1] < 0) exp_err++;
      else if (sl_clr[k-1] && sl_rdata[k-1][64]) begin
        item = {1'b1, a[31:0], 1'b0, sl_rdata[k-1][63:0]};
        exp_q.push_back(item);
        if (sl_sterr[k-1]) exp_err++;
        if (stop_store) break;
      end
      if (max_slots != 0 && k >= max_slots) break;
    end
  endtask

  // ---------------- responder + compare process ----------------
  int          acc_wait = 0, resp_cnt = -1, vcnt = -1, stop_cnt = 0;
  int          ridx = 0, vidx = 0;
  logic        resp_is_st = 1'b0, hold_prev = 1'b0;
  logic [97:0] prev_req = '0;

  always @(negedge clk) begin
    logic [97:0] e;
    logic [31:0] off;
    req_done = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; rdata = '0;
    trvk_en = 1'b0; trvk_clr = 1'b0; stop_from_resp = 1'b0;
    if (done) done_seen++;
    if (hold_prev && lsu_req) check("req_stable", {lsu_we, lsu_addr, lsu_wdata}, prev_req);
    hold_prev = 1'b0;
    if (stop_cnt > 0) begin
      stop_cnt--;
      if (stop_cnt == 0) stop_from_resp = 1'b1;
    end
    if (vcnt > 0) begin
      vcnt--;
      if (vcnt == 0) begin
        trvk_en = 1'b1; trvk_clr = sl_clr[vidx]; vcnt = -1;
      end
    end
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        resp_valid = 1'b1; resp_cnt = -1;
        if (resp_is_st) resp_err = sl_sterr[ridx];
        else begin
          resp_err = sl_lderr[ridx];
          rdata    = sl_rdata[ridx];
          if (!sl_lderr[ridx] && sl_vdly[ridx] >= 0) begin
            vcnt = sl_vdly[ridx] + 1; vidx = ridx;
          end
        end
      end
    end
    if (lsu_req && !rst_i && resp_cnt < 0) begin
      if (acc_wait > 0) begin
        acc_wait--;
        hold_prev = 1'b1;
        prev_req  = {lsu_we, lsu_addr, lsu_wdata};
      end else begin
        req_done = 1'b1;
        acc_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", {lsu_we, lsu_addr}, 33'h0);
          n_checks++; n_errs++;
          $display("FAIL unexpected_req: got request at 0x%0h, expected none", lsu_addr);
        end else begin
          e = exp_q.pop_front();
          check("lsu_we", lsu_we, e[97]);
          check("lsu_addr", lsu_addr, e[96:65]);
          if (e[97]) check("lsu_wdata", lsu_wdata, e[64:0]);
        end
        off        = lsu_addr - scan_start;
        ridx       = int'(off[5:3]);
        resp_is_st = lsu_we;
        resp_cnt   = 1 + resp_extra + int'($urandom_range(0, 2));
        acc_wait   = int'($urandom_range(0, 2));
        if (lsu_we) begin
          n_stores++; last_st_addr = lsu_addr; last_st_wdata = lsu_wdata;
          if (stop_on_store) stop_cnt = 1;
        end else begin
          n_loads++; last_ld_addr = lsu_addr;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_scan(input logic [31:0] s, input logic [31:0] e, input bit stop_at_start,
                          input bit stop_store, input bit poke_start);
    int  base;
    bit  empty;
    build_expected(s, e, stop_at_start ? 1 : 0, stop_store);
    empty = (exp_q.size() == 0);
    stop_on_store = stop_store;
    scan_start = s & ~32'h7;
    n_loads = 0; n_stores = 0;
    base = done_seen;
    @(negedge clk);
    cfg_start_addr = s; cfg_end_addr = e; cfg_start = 1'b1; cfg_stop_main = stop_at_start;
    @(negedge clk);
    cfg_start = 1'b0; cfg_stop_main = 1'b0;
    check("busy_after_start", busy, 1'b1);
    if (empty) check("done_next_cycle", done, 1'b1);
    if (poke_start) begin
      repeat (2) @(negedge clk);
      cfg_start_addr = 32'h9000; cfg_end_addr = 32'h9100; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_seen == base; i++) @(negedge clk);
    if (done_seen == base) begin
      n_checks++; n_errs++;
      $display("FAIL done_timeout: got no done pulse, expected one");
    end
    @(negedge clk);
    check("done_once", 32'(done_seen - base), 32'd1);
    check("busy_idle", busy, 1'b0);
    check("done_low", done, 1'b0);
    check("err_cnt", err_cnt, 16'(exp_err));
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    stop_on_store = 0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    set_slots();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_cnt, 16'h0);
    check("rst_req", lsu_req, 1'b0);
    check("rst_we", lsu_we, 1'b0);
    check("rst_addr", lsu_addr, 32'h0);
    check("rst_wdata", lsu_wdata, 65'h0);
    rst_i = 1'b0;
    @(negedge clk);

    // Stop while idle must not affect the next scan.
    cfg_stop_main = 1'b1;
    @(negedge clk);
    cfg_stop_main = 1'b0;

    // 1: three clean loads, low address bits ignored, start while busy ignored.
    set_slots();
    run_scan(32'h1005, 32'h101C, 0, 0, 1);
    check("t1_loads", n_loads, 3);
    check("t1_stores", n_stores, 0);
    check("t1_last_ld", last_ld_addr, 32'h1010);
    check("t1_err", err_cnt, 16'd0);

    // 2: revoked cap written back with the tag cleared.
    set_slots();
    sl_rdata[0] = 65'h1_AAAA5555_12345678;
    sl_clr[0] = 1'b1;
    run_scan(32'h2000, 32'h2008, 0, 0, 0);
    check("t2_st_addr", last_st_addr, 32'h2000);
    check("t2_st_wdata", last_st_wdata, 65'h0_AAAA5555_12345678);
`ifdef CHERI_TBRE_STATS_EN
    check("t2_scan_cnt", scan_cnt, 32'd1);
    check("t2_rvk_cnt", rvk_cnt, 32'd1);
`endif

    // 3: empty range.
    set_slots();
    run_scan(32'h3000, 32'h3000, 0, 0, 0);
    check("t3_loads", n_loads, 0);

    // 4: load error on slot 1, verdict withheld on slot 2.
    set_slots();
    sl_lderr[1] = 1'b1;
    sl_vdly[2] = -1;
    run_scan(32'h6000, 32'h6018, 0, 0, 0);
    check("t4_err", err_cnt, 16'd2);
    check("t4_loads", n_loads, 3);

    // 5: wrap at the top of the address space.
    set_slots();
    run_scan(32'hFFFF_FFF0, 32'h0, 0, 0, 0);
    check("t5_loads", n_loads, 2);
    check("t5_last_ld", last_ld_addr, 32'hFFFF_FFF8);

    // 6: stop during the store of the first slot.
    set_slots();
    sl_clr[0] = 1'b1;
    run_scan(32'h4000, 32'h4018, 0, 1, 0);
    check("t6_loads", n_loads, 1);
    check("t6_stores", n_stores, 1);

    // 7: tag already clear skips the store; store error counted.
    set_slots();
    sl_rdata[0][64] = 1'b0;
    sl_clr[0] = 1'b1; sl_clr[1] = 1'b1; sl_clr[2] = 1'b1;
    sl_sterr[1] = 1'b1;
    run_scan(32'h7000, 32'h7018, 0, 0, 0);
    check("t7_err", err_cnt, 16'd1);
    check("t7_stores", n_stores, 2);

    // Reset while waiting for a load response; the late response is ignored.
    set_slots();
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h5000, 65'h0});
    scan_start = 32'h5000;
    resp_extra = 5;
    base = acc_count;
    @(negedge clk);
    cfg_start_addr = 32'h5000; cfg_end_addr = 32'h5010; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 50 && acc_count == base; i++) @(negedge clk);
    check("rst_t_accepted", 32'(acc_count - base), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_t_busy", busy, 1'b0);
    check("rst_t_req", lsu_req, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_t_idle", {busy, lsu_req}, 2'b00);
    end
    check("rst_t_err", err_cnt, 16'd0);
    check("rst_t_drained", 32'(exp_q.size()), 32'd0);
    resp_extra = 0;

    // 8: start and stop together scan exactly one slot.
    set_slots();
    run_scan(32'h8000, 32'h8020, 1, 0, 0);
    check("t8_loads", n_loads, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Global bound on simulation time.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected end of sequence");
    $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
